// File: rtl/jk_pkg.sv
// Shared encodings, next-state function and response record for the JK flop bank.
package jk_pkg;

    localparam int MAX_IDXW = 8;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // idx is sized for the largest supported bank; narrower banks zero-extend.
    typedef struct packed {
        logic                src;
        logic [MAX_IDXW-1:0] idx;
        logic                q;
        logic                err;
    } rsp_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            JK_HOLD:  return q;
            JK_RESET: return 1'b0;
            JK_SET:   return 1'b1;
            default:  return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_rr_arb2.sv
// Two-way round-robin arbiter; prio names the requester favoured on contention.
module jk_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1,
    output logic gnt_valid,
    output logic gnt
);

    logic prio;
    logic fire0;
    logic fire1;

    // Readies look only at the other side's valid, so no valid->ready loop.
    assign ready0    = !rst && !(valid1 && prio);
    assign ready1    = !rst && !(valid0 && !prio);
    assign fire0     = valid0 && ready0;
    assign fire1     = valid1 && ready1;
    assign gnt_valid = fire0 || fire1;
    assign gnt       = fire1;

    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (fire0)
            prio <= 1'b1;
        else if (fire1)
            prio <= 1'b0;
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK flops updated one command per cycle by two round-robin requesters.
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [IDXW-1:0]  req0_idx,
    input  logic             req0_j,
    input  logic             req0_k,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [IDXW-1:0]  req1_idx,
    input  logic             req1_j,
    input  logic             req1_k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             rsp_valid,
    output logic             rsp_src,
    output logic [IDXW-1:0]  rsp_idx,
    output logic             rsp_q,
    output logic             rsp_err
);

    logic             gnt_valid;
    logic             gnt;
    logic [IDXW-1:0]  sel_idx;
    logic             sel_j;
    logic             sel_k;
    logic [WIDTH-1:0] q_nxt;
    logic             new_bit;
    logic             hit;
    rsp_t             rsp_r;

    jk_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .ready0    (req0_ready),
        .ready1    (req1_ready),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign sel_idx = gnt ? req1_idx : req0_idx;
    assign sel_j   = gnt ? req1_j   : req0_j;
    assign sel_k   = gnt ? req1_k   : req0_k;

    // One-hot decode doubles as the range check: an index past WIDTH matches nothing.
    always_comb begin
        q_nxt   = q;
        new_bit = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_idx == IDXW'(i)) begin
                hit      = 1'b1;
                new_bit  = jk_next(q[i], sel_j, sel_k);
                q_nxt[i] = new_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
        end else begin
            rsp_valid <= gnt_valid;
            if (gnt_valid) begin
                q     <= q_nxt;
                rsp_r <= '{src: gnt, idx: MAX_IDXW'(sel_idx), q: new_bit, err: !hit};
            end
        end
    end

    assign qn      = ~q;
    assign rsp_src = rsp_r.src;
    assign rsp_idx = IDXW'(rsp_r.idx);
    assign rsp_q   = rsp_r.q;
    assign rsp_err = rsp_r.err;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench: expected responses queued at issue, popped by a negedge monitor.
module tb_jk_bank_arbiter;
    import jk_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-flop bank
    logic       a0_valid, a0_ready, a0_j, a0_k;
    logic [2:0] a0_idx;
    logic       a1_valid, a1_ready, a1_j, a1_k;
    logic [2:0] a1_idx;
    logic [7:0] a_q, a_qn;
    logic       a_rsp_valid, a_rsp_src, a_rsp_q, a_rsp_err;
    logic [2:0] a_rsp_idx;

    // 6-flop bank, exercises out-of-range indices
    logic       b0_valid, b0_ready, b0_j, b0_k;
    logic [2:0] b0_idx;
    logic       b1_valid, b1_ready, b1_j, b1_k;
    logic [2:0] b1_idx;
    logic [5:0] b_q, b_qn;
    logic       b_rsp_valid, b_rsp_src, b_rsp_q, b_rsp_err;
    logic [2:0] b_rsp_idx;

    jk_bank_arbiter #(.WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(a0_valid), .req0_ready(a0_ready), .req0_idx(a0_idx), .req0_j(a0_j), .req0_k(a0_k),
        .req1_valid(a1_valid), .req1_ready(a1_ready), .req1_idx(a1_idx), .req1_j(a1_j), .req1_k(a1_k),
        .q(a_q), .qn(a_qn), .rsp_valid(a_rsp_valid), .rsp_src(a_rsp_src),
        .rsp_idx(a_rsp_idx), .rsp_q(a_rsp_q), .rsp_err(a_rsp_err)
    );

    jk_bank_arbiter #(.WIDTH(6)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b0_valid), .req0_ready(b0_ready), .req0_idx(b0_idx), .req0_j(b0_j), .req0_k(b0_k),
        .req1_valid(b1_valid), .req1_ready(b1_ready), .req1_idx(b1_idx), .req1_j(b1_j), .req1_k(b1_k),
        .q(b_q), .qn(b_qn), .rsp_valid(b_rsp_valid), .rsp_src(b_rsp_src),
        .rsp_idx(b_rsp_idx), .rsp_q(b_rsp_q), .rsp_err(b_rsp_err)
    );

    int   tests = 0;
    int   fails = 0;
    rsp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic s, input logic [2:0] i, input logic qq, input logic e);
        rsp_t r;
        r = '{src: s, idx: MAX_IDXW'(i), q: qq, err: e};
        sb.push_back(r);
    endtask

    // Monitor for bank A
    always @(negedge clk) begin
        if (a_rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(a_rsp_valid), 32'(0));
            end else begin
                rsp_t e, a;
                e = sb.pop_front();
                a = '{src: a_rsp_src, idx: MAX_IDXW'(a_rsp_idx), q: a_rsp_q, err: a_rsp_err};
                chk("rsp", 32'(a), 32'(e));
            end
        end
    end

    logic [1:0] jk_cmd [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic [7:0] jk_q   [5] = '{8'h28, 8'h08, 8'h28, 8'h08, 8'h08};
    logic [1:0] ret_cmd[3] = '{2'b10, 2'b11, 2'b11};
    logic       ret_bit[3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        a0_valid = 1'b1; a0_idx = 3'd0; a0_j = 1'b1; a0_k = 1'b1;
        a1_valid = 1'b1; a1_idx = 3'd0; a1_j = 1'b1; a1_k = 1'b1;
        b0_valid = 1'b0; b0_idx = 3'd0; b0_j = 1'b0; b0_k = 1'b0;
        b1_valid = 1'b0; b1_idx = 3'd0; b1_j = 1'b0; b1_k = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_q", 32'(a_q), 32'h00);
        chk("reset_qn", 32'(a_qn), 32'hFF);
        chk("reset_ready0", 32'(a0_ready), 32'(0));
        chk("reset_ready1", 32'(a1_ready), 32'(0));
        chk("reset_rsp_valid", 32'(a_rsp_valid), 32'(0));

        // first command after reset
        rst = 1'b0; a1_valid = 1'b0;
        a0_idx = 3'd3; a0_j = 1'b1; a0_k = 1'b0;
        #1 chk("first_ready0", 32'(a0_ready), 32'(1));
        expect_rsp(1'b0, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        chk("first_q", 32'(a_q), 32'h08);
        chk("first_qn", 32'(a_qn), 32'hF7);

        // JK truth table on idx 5
        for (int i = 0; i < 5; i++) begin
            a0_idx = 3'd5; {a0_j, a0_k} = jk_cmd[i];
            expect_rsp(1'b0, 3'd5, jk_q[i][5], 1'b0);
            @(negedge clk);
            chk("jk_q", 32'(a_q), 32'(jk_q[i]));
        end

        // lone req1 hold: still a transaction, hands prio back to 0
        a0_valid = 1'b0;
        a1_valid = 1'b1; a1_idx = 3'd1; a1_j = 1'b0; a1_k = 1'b0;
        expect_rsp(1'b1, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_q", 32'(a_q), 32'h08);

        // contention: both toggle idx 0, grants alternate 0,1,...
        for (int i = 0; i < 6; i++) begin
            a0_valid = 1'b1; a0_idx = 3'd0; a0_j = 1'b1; a0_k = 1'b1;
            a1_valid = 1'b1; a1_idx = 3'd0; a1_j = 1'b1; a1_k = 1'b1;
            #1;
            chk("cont_ready0", 32'(a0_ready), 32'(i % 2 == 0));
            chk("cont_ready1", 32'(a1_ready), 32'(i % 2 == 1));
            expect_rsp(1'(i % 2), 3'd0, (i % 2 == 0), 1'b0);
            @(negedge clk);
        end
        chk("cont_q", 32'(a_q), 32'h08);

        // priority retention: req1 wins once, then req0 alone back to back
        a0_valid = 1'b0;
        a1_idx = 3'd2; a1_j = 1'b1; a1_k = 1'b0;
        expect_rsp(1'b1, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        chk("ret_q1", 32'(a_q), 32'h0C);
        a1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a0_valid = 1'b1; a0_idx = 3'd6; {a0_j, a0_k} = ret_cmd[i];
            #1 chk("ret_ready0", 32'(a0_ready), 32'(1));
            expect_rsp(1'b0, 3'd6, ret_bit[i], 1'b0);
            @(negedge clk);
        end
        chk("ret_q2", 32'(a_q), 32'h4C);
        a0_idx = 3'd6; a0_j = 1'b0; a0_k = 1'b0;
        a1_valid = 1'b1; a1_idx = 3'd7; a1_j = 1'b1; a1_k = 1'b0;
        #1;
        chk("ret_prio_ready0", 32'(a0_ready), 32'(0));
        chk("ret_prio_ready1", 32'(a1_ready), 32'(1));
        expect_rsp(1'b1, 3'd7, 1'b1, 1'b0);
        @(negedge clk);
        chk("ret_q3", 32'(a_q), 32'hCC);

        // reset in the cycle after an accept
        a1_valid = 1'b0;
        a0_idx = 3'd1; a0_j = 1'b1; a0_k = 1'b1;
        expect_rsp(1'b0, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_q_before", 32'(a_q), 32'hCE);
        rst = 1'b1;
        #1 chk("mid_ready0_rst", 32'(a0_ready), 32'(0));
        @(negedge clk);
        chk("mid_q", 32'(a_q), 32'h00);
        chk("mid_qn", 32'(a_qn), 32'hFF);
        chk("mid_rsp_valid", 32'(a_rsp_valid), 32'(0));
        rst = 1'b0; a1_valid = 1'b1;
        #1;
        chk("mid_prio_ready0", 32'(a0_ready), 32'(1));
        chk("mid_prio_ready1", 32'(a1_ready), 32'(0));
        a0_valid = 1'b0; a1_valid = 1'b0;
        @(negedge clk);

        // 6-flop bank: in-range set, then out-of-range toggle
        b0_valid = 1'b1; b0_idx = 3'd2; b0_j = 1'b1; b0_k = 1'b0;
        #1 chk("oor_ready_a", 32'(b0_ready), 32'(1));
        @(negedge clk);
        chk("oor_set_q", 32'(b_q), 32'h04);
        chk("oor_set_rsp", 32'({b_rsp_valid, b_rsp_src, b_rsp_idx, b_rsp_q, b_rsp_err}), 32'b1_0_010_1_0);
        b0_idx = 3'd7; b0_j = 1'b1; b0_k = 1'b1;
        #1 chk("oor_ready_b", 32'(b0_ready), 32'(1));
        @(negedge clk);
        chk("oor_q", 32'(b_q), 32'h04);
        chk("oor_qn", 32'(b_qn), 32'h3B);
        chk("oor_rsp", 32'({b_rsp_valid, b_rsp_src, b_rsp_idx, b_rsp_q, b_rsp_err}), 32'b1_0_111_0_1);
        b0_valid = 1'b0;
        @(negedge clk);
        chk("oor_rsp_pulse", 32'(b_rsp_valid), 32'(0));

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Arbitrated controller for a bank of `WIDTH` JK flip-flops shared between two requesters. Each requester issues single-flop JK commands (index, J, K) over a valid/ready handshake. A round-robin arbiter grants at most one command per clock. The granted command updates the addressed flop per the JK truth table, and a one-cycle response returns the new value. The block sits between command sources (test sequencers, counters) and any logic consuming the flop-bank state `q`/`qn`.

## Interface
- `WIDTH`, 8: number of JK flops in the bank; range 2..256.
- `IDXW`, `$clog2(WIDTH)`: index width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 command present.
- `req0_ready`  out  1  requester 0 command accepted this cycle if valid.
- `req0_idx`  in  IDXW  requester 0 target flop.
- `req0_j`, `req0_k`  in  1 each  requester 0 J/K inputs.
- `req1_valid`, `req1_ready`, `req1_idx`, `req1_j`, `req1_k`: same as requester 0, for requester 1.
- `q`  out  WIDTH  flop-bank state.
- `qn`  out  WIDTH  always `~q`.
- `rsp_valid`  out  1  one-cycle pulse, one per accepted command.
- `rsp_src`  out  1  requester that issued the responded command.
- `rsp_idx`  out  IDXW  index of the responded command.
- `rsp_q`  out  1  new value of the addressed flop; 0 when `rsp_err`.
- `rsp_err`  out  1  index was ≥ `WIDTH`; bank unchanged.

## Operation
- **Handshake:** a command transfers when `valid && ready` at a rising edge. The requester holds idx/j/k stable while valid and unaccepted. Dropping valid before acceptance is permitted and leaves no side effects.
- **Ready logic:** `ready` does not depend on the requester's own `valid`.
  - `req0_ready = !(req1_valid && prio)`.
  - `req1_ready = !(req0_valid && !prio)`.
- **Priority bit `prio`:** 0 favours requester 0, 1 favours requester 1.
  - After any transfer, `prio` points to the requester that was not served.
  - With no transfer, `prio` holds.
  - With a single active requester, that requester is served every cycle.
- **JK update on accepted command, for `q[idx]`:**
  - `00` holds.
  - `01` resets to 0.
  - `10` sets to 1.
  - `11` toggles.
  - Other bits of `q` are unchanged.
- **Hold command (`00`):** still a full transaction. It consumes the grant, flips `prio` and produces a response.
- **Out-of-range index** (only possible when `WIDTH` is not a power of 2): accepted, bank unchanged, response with `rsp_err=1` and `rsp_q=0`.
- **Contention:** both requesters may target the same index. Only one is granted per cycle, so there is no write conflict. The loser is served the next cycle, against the already-updated value.
- **Reset values:**
  - `q` = all 0 and `qn` = all 1.
  - `prio` = 0.
  - `rsp_valid`, `rsp_src`, `rsp_idx`, `rsp_q`, `rsp_err` = 0.
- **Reset mid-operation:** a command presented in a cycle with `rst=1` is not accepted; both readies are low while `rst`. No response is emitted for it, and any pending `rsp_valid` is cleared.

## Timing
- **Accept to update:** command accepted at edge N. `q`/`qn` reflect the update from edge N on.
- **Response:** `rsp_*` registered at edge N, valid for exactly one cycle (N to N+1).
- **Throughput:** one command per cycle total. Under continuous contention the requesters alternate 0,1,0,1 starting from the current `prio`.
- **No backpressure on responses:** the consumer must always sample `rsp_valid`.
- **Ready path:** `ready` is combinational from the other requester's `valid` and `prio`. There is no combinational path from idx/j/k to any output.

## Structure
- Package `jk_pkg`:
  - Command encodings `JK_HOLD=2'b00`, `JK_RESET=2'b01`, `JK_SET=2'b10`, `JK_TOGGLE=2'b11`.
  - Function `jk_next(q, j, k)` returning the next state.
  - Response struct (src, idx, q, err).
- Sub-module `jk_rr_arb2`: two-way round-robin arbiter owning `prio`. Inputs: both valids. Outputs: both readies and the grant index.
- Top level holds the bank register, the index decode/range check and the response register.

## Test plan
- **Reset:** `rst` high for 2 cycles with both valids high. Expect `q=8'h00`, `qn=8'hFF`, both readies 0, `rsp_valid=0`. Release reset, `req0` alone idx=3 j=1 k=0. Expect `q=8'h08` after one edge, `rsp_valid=1`, `rsp_src=0`, `rsp_q=1`.
- **JK table on idx 5:** from 0, issue 10, 11, 11, 01, 00. Expect `q[5]` = 1, 0, 1, 0, 0, with `rsp_q` matching each cycle.
- **Contention:** both requesters valid for 6 cycles, each toggling idx 0. Expect grants 0,1,0,1,0,1, `rsp_src` alternating, and `q[0]` ending at 0.
- **Priority retention:** `req1` wins once, then only `req0` is valid for 3 cycles. All 3 are served back to back, and `prio` points to 1 afterwards.
- **Out of range:** `WIDTH=6`, `req0` idx=7 j=1 k=1. Expect accepted, `q` unchanged, `rsp_err=1`, `rsp_q=0`.
- **Reset mid-stream:** `rst` asserted in the cycle after an accept. Expect `rsp_valid` cleared, `q=0`, `prio=0` on the next edge.
